// File: rtl/pipe_ctrl_pkg.sv
// Shared pipeline-control types and defaults.
// Used by the pipe_ctrl FSM, its hazard unit and its interface.
package pipe_ctrl_pkg;

    localparam int REG_W           = 5;
    localparam int WAIT_W          = 8;
    localparam int STALL_CNT_W     = 16;
    localparam int MEM_TIMEOUT_DEF = 64;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Pipeline-side bundle of hazard inputs and stall/flush/memory outputs.
// The master drives hazard inputs; the slave is the controller.
interface pipe_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic                   isLd_EX;
    logic [REG_W-1:0]       rd_EX;
    logic [REG_W-1:0]       rs1_OF;
    logic [REG_W-1:0]       rs2_OF;
    logic                   useRs1_OF;
    logic                   useRs2_OF;
    logic                   isBranchTaken_EX;
    logic                   memAccess_DM;
    logic                   dmem_ready;

    logic                   dmem_req;
    logic                   stall_PC;
    logic                   stall_IFOF;
    logic                   stall_OFEX;
    logic                   stall_EXDM;
    logic                   stall_DMWB;
    logic                   flush_IFOF;
    logic                   flush_OFEX;
    logic                   err_timeout;
    logic [STALL_CNT_W-1:0] stall_cycles;

    modport master (
        output isLd_EX, rd_EX, rs1_OF, rs2_OF,
        output useRs1_OF, useRs2_OF,
        output isBranchTaken_EX, memAccess_DM, dmem_ready,
        input  dmem_req, stall_PC, stall_IFOF, stall_OFEX,
        input  stall_EXDM, stall_DMWB, flush_IFOF, flush_OFEX,
        input  err_timeout, stall_cycles
    );

    modport slave (
        input  isLd_EX, rd_EX, rs1_OF, rs2_OF,
        input  useRs1_OF, useRs2_OF,
        input  isBranchTaken_EX, memAccess_DM, dmem_ready,
        output dmem_req, stall_PC, stall_IFOF, stall_OFEX,
        output stall_EXDM, stall_DMWB, flush_IFOF, flush_OFEX,
        output err_timeout, stall_cycles
    );

endinterface

// File: rtl/pipe_ctrl_hazard_detect.sv
// Load-use comparator between the EX load and the OF sources.
// Register 0 is compared like any other register.
module pipe_ctrl_hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic             i_is_ld,
    input  logic [REG_W-1:0] i_rd,
    input  logic [REG_W-1:0] i_rs1,
    input  logic [REG_W-1:0] i_rs2,
    input  logic             i_use_rs1,
    input  logic             i_use_rs2,
    output logic             o_load_use
);

    logic w_hit1;
    logic w_hit2;

    assign w_hit1     = i_use_rs1 & (i_rs1 == i_rd);
    assign w_hit2     = i_use_rs2 & (i_rs2 == i_rd);
    assign o_load_use = i_is_ld & (w_hit1 | w_hit2);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with a data-memory wait FSM.
// Priority: memory stall, then branch flush, then load-use bubble.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst,
    pipe_ctrl_if.slave  bus
);

    localparam logic [WAIT_W-1:0] TO = WAIT_W'(MEM_TIMEOUT);

    state_t                 r_state;
    state_t                 w_next;
    logic [WAIT_W-1:0]      r_wait_cnt;
    logic [WAIT_W-1:0]      w_cnt_nxt;
    logic                   r_err;
    logic [STALL_CNT_W-1:0] r_stall_cnt;

    logic w_load_use;
    logic w_mem_stall;
    logic w_req;
    logic w_err_set;
    logic w_br_flush;
    logic w_lu_stall;
    logic w_any_stall;

    pipe_ctrl_hazard_detect u_hazard (
        .i_is_ld    (bus.isLd_EX),
        .i_rd       (bus.rd_EX),
        .i_rs1      (bus.rs1_OF),
        .i_rs2      (bus.rs2_OF),
        .i_use_rs1  (bus.useRs1_OF),
        .i_use_rs2  (bus.useRs2_OF),
        .o_load_use (w_load_use)
    );

    always_comb begin
        w_next      = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_mem_stall = 1'b0;
        w_req       = 1'b0;
        w_err_set   = 1'b0;
        unique case (r_state)
            RUN: begin
                w_req = bus.memAccess_DM;
                if (bus.memAccess_DM && !bus.dmem_ready) begin
                    w_mem_stall = 1'b1;
                    w_next      = MEM_WAIT;
                    w_cnt_nxt   = WAIT_W'(1);
                end
            end
            MEM_WAIT: begin
                w_req = 1'b1;
                if (bus.dmem_ready) begin
                    w_next    = RUN;
                    w_cnt_nxt = '0;
                end else if (r_wait_cnt >= TO) begin
                    // Forced release: let the pipe move on, flag the error
                    w_err_set = 1'b1;
                    w_next    = RUN;
                    w_cnt_nxt = '0;
                end else begin
                    w_mem_stall = 1'b1;
                    w_cnt_nxt   = r_wait_cnt + WAIT_W'(1);
                end
            end
        endcase
    end

    assign w_br_flush  = !w_mem_stall & bus.isBranchTaken_EX;
    assign w_lu_stall  = !w_mem_stall & !bus.isBranchTaken_EX & w_load_use;
    assign w_any_stall = w_mem_stall | w_lu_stall;

    assign bus.dmem_req   = !rst & w_req;
    assign bus.stall_PC   = !rst & w_any_stall;
    assign bus.stall_IFOF = !rst & w_any_stall;
    assign bus.stall_OFEX = !rst & w_mem_stall;
    assign bus.stall_EXDM = !rst & w_mem_stall;
    assign bus.stall_DMWB = !rst & w_mem_stall;
    assign bus.flush_IFOF = !rst & w_br_flush;
    assign bus.flush_OFEX = !rst & (w_br_flush | w_lu_stall);

    assign bus.err_timeout  = r_err;
    assign bus.stall_cycles = r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_wait_cnt <= w_cnt_nxt;
            r_err      <= r_err | w_err_set;
            if (w_any_stall && (r_stall_cnt != '1))
                r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
        end
    end

endmodule
